// File: rtl/wb_stream_reader_mcfg.sv
// Wishbone config block for a multi-channel stream reader.
// Global IRQ regs plus per-channel DMA setup and auto-restart.
module wb_stream_reader_mcfg #(
  parameter int WB_AW = 32,
  parameter int WB_DW = 32,
  parameter int NCH   = 2,
  parameter int BPW   = 4
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  input  logic [7:0]             wb_adr_i,
  input  logic [WB_DW-1:0]       wb_dat_i,
  input  logic [WB_DW/8-1:0]     wb_sel_i,
  input  logic                   wb_we_i,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  input  logic [2:0]             wb_cti_i,
  input  logic [1:0]             wb_bte_i,
  output logic [WB_DW-1:0]       wb_dat_o,
  output logic                   wb_ack_o,
  output logic                   wb_err_o,
  output logic                   irq,
  input  logic [NCH-1:0]         busy,
  output logic [NCH-1:0]         enable,
  input  logic [NCH*WB_DW-1:0]   tx_cnt,
  output logic [NCH*WB_AW-1:0]   start_adr,
  output logic [NCH*WB_AW-1:0]   buf_size,
  output logic [NCH*WB_AW-1:0]   burst_size
);

  typedef logic [NCH-1:0][WB_AW-1:0] adr_arr_t;

  logic [2:0]       slot;
  logic [2:0]       rsel;
  logic             req;
  logic             bad;
  logic             wr;
  logic [NCH-1:0]   evt;
  logic [NCH-1:0]   w1c;
  logic [NCH-1:0]   srst;
  logic [NCH-1:0]   sw_start;
  logic [WB_DW-1:0] rdata;
  logic             unused_ok;

  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [WB_DW-1:0] dat_q, dat_d;
  logic [NCH-1:0]   busy_r_q, busy_r_d;
  logic [NCH-1:0]   stat_q, stat_d;
  logic [NCH-1:0]   mask_q, mask_d;
  logic [NCH-1:0]   cont_q, cont_d;
  logic [NCH-1:0]   en_q, en_d;
  adr_arr_t         sadr_q, sadr_d;
  adr_arr_t         bsz_q, bsz_d;
  adr_arr_t         brst_q, brst_d;

  assign slot = wb_adr_i[7:5];
  assign rsel = wb_adr_i[4:2];
  assign req  = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
  assign bad  = slot > 3'(NCH);
  assign wr   = req & wb_we_i & ~bad;
  assign evt  = busy_r_q & ~busy;

  assign unused_ok = ^{wb_sel_i, wb_cti_i, wb_bte_i, wb_adr_i[1:0]};

  // Bus decode, register updates, event capture and restart pulses
  always_comb begin
    ack_d    = req & ~bad;
    err_d    = req & bad;
    dat_d    = dat_q;
    busy_r_d = busy;
    stat_d   = stat_q;
    mask_d   = mask_q;
    cont_d   = cont_q;
    en_d     = '0;
    sadr_d   = sadr_q;
    bsz_d    = bsz_q;
    brst_d   = brst_q;
    w1c      = '0;
    srst     = '0;
    sw_start = '0;
    rdata    = '0;

    if (slot == 3'd0) begin
      case (rsel)
        3'd0:    rdata = WB_DW'(stat_q);
        3'd1:    rdata = WB_DW'(mask_q);
        3'd2:    rdata = WB_DW'({16'h0001, 8'(BPW), 8'(NCH)});
        default: rdata = '0;
      endcase
      if (wr && rsel == 3'd0) w1c = wb_dat_i[NCH-1:0];
      if (wr && rsel == 3'd1) mask_d = wb_dat_i[NCH-1:0];
    end

    for (int c = 0; c < NCH; c++) begin
      if (slot == 3'(c + 1)) begin
        case (rsel)
          3'd0:    rdata = WB_DW'({cont_q[c], stat_q[c], busy_r_q[c]});
          3'd1:    rdata = WB_DW'(sadr_q[c]);
          3'd2:    rdata = WB_DW'(bsz_q[c]);
          3'd3:    rdata = WB_DW'(brst_q[c]);
          3'd4:    rdata = WB_DW'(tx_cnt[c*WB_DW +: WB_DW] * WB_DW'(BPW));
          default: rdata = '0;
        endcase
        if (wr) begin
          case (rsel)
            3'd0: begin
              if (wb_dat_i[2]) begin
                srst[c] = 1'b1;
              end else begin
                cont_d[c]   = wb_dat_i[1];
                sw_start[c] = wb_dat_i[0];
              end
            end
            3'd1:    sadr_d[c] = WB_AW'(wb_dat_i);
            3'd2:    bsz_d[c]  = WB_AW'(wb_dat_i);
            3'd3:    brst_d[c] = WB_AW'(wb_dat_i);
            default: ;
          endcase
        end
      end

      if (srst[c]) begin
        sadr_d[c] = '0;
        bsz_d[c]  = '0;
        brst_d[c] = '0;
        cont_d[c] = 1'b0;
      end
      stat_d[c] = evt[c] | (stat_q[c] & ~w1c[c] & ~srst[c]);
      en_d[c]   = ~srst[c] & (sw_start[c] | (evt[c] & cont_q[c]));
    end

    if (req) dat_d = bad ? '0 : rdata;
  end

  // State registers, cleared asynchronously
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dat_q    <= '0;
      busy_r_q <= '0;
      stat_q   <= '0;
      mask_q   <= '0;
      cont_q   <= '0;
      en_q     <= '0;
      sadr_q   <= '0;
      bsz_q    <= '0;
      brst_q   <= '0;
    end else begin
      ack_q    <= ack_d;
      err_q    <= err_d;
      dat_q    <= dat_d;
      busy_r_q <= busy_r_d;
      stat_q   <= stat_d;
      mask_q   <= mask_d;
      cont_q   <= cont_d;
      en_q     <= en_d;
      sadr_q   <= sadr_d;
      bsz_q    <= bsz_d;
      brst_q   <= brst_d;
    end
  end

  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign wb_dat_o   = dat_q;
  assign enable     = en_q;
  assign irq        = |(stat_q & mask_q);
  assign start_adr  = sadr_q;
  assign buf_size   = bsz_q;
  assign burst_size = brst_q;

endmodule

// File: tb/tb_wb_stream_reader_mcfg.sv
// Directed bench for wb_stream_reader_mcfg.
// Vector table for register access plus IRQ/restart/reset sequences.
module tb_wb_stream_reader_mcfg;

  localparam int NCH = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        adr;
  logic [DW-1:0]     dat_i;
  logic [DW/8-1:0]   sel;
  logic              we, cyc, stb;
  logic [2:0]        cti;
  logic [1:0]        bte;
  logic [DW-1:0]     dat_o;
  logic              ack, err, irq;
  logic [NCH-1:0]    busy;
  logic [NCH-1:0]    enable;
  logic [NCH*DW-1:0] tx_cnt;
  logic [NCH*AW-1:0] start_adr, buf_size, burst_size;

  int errors = 0;
  int checks = 0;
  int en0_cnt = 0;
  int en1_cnt = 0;

  always #5 clk = ~clk;

  wb_stream_reader_mcfg #(
    .WB_AW(AW), .WB_DW(DW), .NCH(NCH), .BPW(4)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wb_adr_i  (adr),
    .wb_dat_i  (dat_i),
    .wb_sel_i  (sel),
    .wb_we_i   (we),
    .wb_cyc_i  (cyc),
    .wb_stb_i  (stb),
    .wb_cti_i  (cti),
    .wb_bte_i  (bte),
    .wb_dat_o  (dat_o),
    .wb_ack_o  (ack),
    .wb_err_o  (err),
    .irq       (irq),
    .busy      (busy),
    .enable    (enable),
    .tx_cnt    (tx_cnt),
    .start_adr (start_adr),
    .buf_size  (buf_size),
    .burst_size(burst_size)
  );

  always @(negedge clk) begin
    if (enable[0]) en0_cnt++;
    if (enable[1]) en1_cnt++;
  end

  typedef struct {
    logic        we;
    logic [7:0]  adr;
    logic [31:0] dat;
    logic        ack;
    logic        err;
    logic [31:0] rd;
    logic        chk;
  } vec_t;

  localparam int NV = 21;
  vec_t vt [NV];

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // one access: idle edge first so the previous ack has cleared
  task automatic bus(input logic w, input logic [7:0] a,
                     input logic [31:0] d, output logic ak,
                     output logic er, output logic [31:0] rd);
    @(posedge clk);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d;
    @(posedge clk);
    #1;
    ak = ack; er = err; rd = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic busy_pulse0();
    @(negedge clk);
    busy[0] = 1'b1;
    @(negedge clk);
    busy[0] = 1'b0;
  endtask

  logic        a, e;
  logic [31:0] r;
  int          base0;

  initial begin
    vt[0]  = '{1'b1, 8'h24, 32'h1000,     1'b1, 1'b0, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 8'h24, 32'h0,        1'b1, 1'b0, 32'h1000,     1'b1};
    vt[2]  = '{1'b0, 8'h50, 32'h0,        1'b1, 1'b0, 32'h40,       1'b1};
    vt[3]  = '{1'b0, 8'h30, 32'h0,        1'b1, 1'b0, 32'h1C,       1'b1};
    vt[4]  = '{1'b0, 8'h60, 32'h0,        1'b0, 1'b1, 32'h0,        1'b1};
    vt[5]  = '{1'b1, 8'h60, 32'hDEAD,     1'b0, 1'b1, 32'h0,        1'b1};
    vt[6]  = '{1'b0, 8'h08, 32'h0,        1'b1, 1'b0, 32'h00010402, 1'b1};
    vt[7]  = '{1'b1, 8'h04, 32'h1,        1'b1, 1'b0, 32'h0,        1'b0};
    vt[8]  = '{1'b0, 8'h04, 32'h0,        1'b1, 1'b0, 32'h1,        1'b1};
    vt[9]  = '{1'b1, 8'h48, 32'hABCD,     1'b1, 1'b0, 32'h0,        1'b0};
    vt[10] = '{1'b0, 8'h48, 32'h0,        1'b1, 1'b0, 32'hABCD,     1'b1};
    vt[11] = '{1'b1, 8'h2C, 32'h55,       1'b1, 1'b0, 32'h0,        1'b0};
    vt[12] = '{1'b0, 8'h2C, 32'h0,        1'b1, 1'b0, 32'h55,       1'b1};
    vt[13] = '{1'b0, 8'h34, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1};
    vt[14] = '{1'b1, 8'h08, 32'hFFFF,     1'b1, 1'b0, 32'h0,        1'b0};
    vt[15] = '{1'b0, 8'h08, 32'h0,        1'b1, 1'b0, 32'h00010402, 1'b1};
    vt[16] = '{1'b1, 8'h50, 32'h7B,       1'b1, 1'b0, 32'h0,        1'b0};
    vt[17] = '{1'b0, 8'h50, 32'h0,        1'b1, 1'b0, 32'h40,       1'b1};
    vt[18] = '{1'b0, 8'hE0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b1};
    vt[19] = '{1'b0, 8'h28, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1};
    vt[20] = '{1'b0, 8'h20, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1};

    rst_n = 1'b0;
    adr = '0; dat_i = '0; sel = '1; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    cti = '0; bte = '0; busy = '0;
    tx_cnt = {32'h10, 32'h7};

    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_dat", dat_o, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_en", 32'(enable), 32'h0);
    check("rst_sadr0", start_adr[31:0], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      bus(vt[i].we, vt[i].adr, vt[i].dat, a, e, r);
      check($sformatf("v%0d_ack", i), 32'(a), 32'(vt[i].ack));
      check($sformatf("v%0d_err", i), 32'(e), 32'(vt[i].err));
      if (vt[i].chk) check($sformatf("v%0d_dat", i), r, vt[i].rd);
    end
    check("sadr0", start_adr[31:0], 32'h1000);
    check("sadr1", start_adr[63:32], 32'h0);
    check("bsz1", buf_size[63:32], 32'hABCD);
    check("brst0", burst_size[31:0], 32'h55);

    // back-to-back with stb held: one access per two cycles
    @(posedge clk);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h08;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold_ack%0d", k), 32'(ack), (k % 2 == 0) ? 32'h1 : 32'h0);
    end
    cyc = 1'b0; stb = 1'b0;

    // interrupt on busy fall, W1C colliding with a new fall
    busy_pulse0();
    @(posedge clk);
    #1;
    check("irq_set", 32'(irq), 32'h1);
    bus(1'b0, 8'h00, 32'h0, a, e, r);
    check("stat_set", r, 32'h1);
    @(negedge clk);
    busy[0] = 1'b1;
    @(negedge clk);
    busy[0] = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h00; dat_i = 32'h1;
    @(posedge clk);
    #1;
    check("w1c_coll_ack", 32'(ack), 32'h1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    bus(1'b0, 8'h00, 32'h0, a, e, r);
    check("stat_coll", r, 32'h1);
    bus(1'b1, 8'h00, 32'h1, a, e, r);
    bus(1'b0, 8'h00, 32'h0, a, e, r);
    check("stat_clr", r, 32'h0);
    check("irq_clr", 32'(irq), 32'h0);

    // start plus continuous auto-restart on ch0
    base0 = en0_cnt;
    bus(1'b1, 8'h20, 32'h3, a, e, r);
    check("sw_en", 32'(enable[0]), 32'h1);
    @(posedge clk);
    #1;
    check("sw_en_off", 32'(enable[0]), 32'h0);
    for (int k = 0; k < 2; k++) begin
      busy_pulse0();
      @(posedge clk);
      #1;
      check($sformatf("auto_en%0d", k), 32'(enable[0]), 32'h1);
      @(posedge clk);
      #1;
      check($sformatf("auto_off%0d", k), 32'(enable[0]), 32'h0);
    end
    bus(1'b1, 8'h20, 32'h0, a, e, r);
    busy_pulse0();
    repeat (3) @(posedge clk);
    #1;
    check("en0_pulses", 32'(en0_cnt - base0), 32'd3);

    // ch1 soft reset leaves ch0 and mask alone
    bus(1'b1, 8'h44, 32'h2222, a, e, r);
    bus(1'b1, 8'h4C, 32'h33, a, e, r);
    bus(1'b1, 8'h40, 32'h2, a, e, r);
    check("sadr1_cfg", start_adr[63:32], 32'h2222);
    bus(1'b1, 8'h40, 32'h5, a, e, r);
    check("srst_sadr1", start_adr[63:32], 32'h0);
    check("srst_bsz1", buf_size[63:32], 32'h0);
    check("srst_brst1", burst_size[63:32], 32'h0);
    bus(1'b0, 8'h40, 32'h0, a, e, r);
    check("srst_ctrl1", r, 32'h0);
    check("srst_sadr0", start_adr[31:0], 32'h1000);
    check("srst_brst0", burst_size[31:0], 32'h55);
    bus(1'b0, 8'h04, 32'h0, a, e, r);
    check("srst_mask", r, 32'h1);
    repeat (2) @(posedge clk);
    check("en1_none", 32'(en1_cnt), 32'h0);

    // reset while an ack is on the bus
    check("pre_rst_irq", 32'(irq), 32'h1);
    @(posedge clk);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h24;
    @(posedge clk);
    #1;
    check("pre_rst_ack", 32'(ack), 32'h1);
    check("pre_rst_dat", dat_o, 32'h1000);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack", 32'(ack), 32'h0);
    check("mid_rst_err", 32'(err), 32'h0);
    check("mid_rst_dat", dat_o, 32'h0);
    check("mid_rst_irq", 32'(irq), 32'h0);
    check("mid_rst_en", 32'(enable), 32'h0);
    check("mid_rst_sadr0", start_adr[31:0], 32'h0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus(1'b0, 8'h24, 32'h0, a, e, r);
    check("post_rst_ack", 32'(a), 32'h1);
    check("post_rst_dat", r, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
